mips_prog_loader: RTL and testbench

Sequential instruction encoder and program loader for the single-cycle MIPS core. It accepts a stream of symbolic instructions (kind plus fields) over a valid/ready handshake, packs each one into a 32-bit MIPS word and writes it into instruction memory at auto-incrementing addresses. It holds the CPU in reset while loading and releases it once an END beat is accepted. It emits exactly the opcodes the core's main decoder recognises: RTYPE, LW, SW, BEQ, ADDI and J.

---
 rtl/mips_prog_loader.sv | 124 ++++++++++++
 tb/tb_mips_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Program loader for the single-cycle MIPS core: encodes a stream of symbolic
// instructions into 32-bit words and writes them to imem while holding the CPU in reset.
module mips_prog_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERROR} state_e;

    localparam logic [2:0] K_RTYPE = 3'd0;
    localparam logic [2:0] K_LW    = 3'd1;
    localparam logic [2:0] K_SW    = 3'd2;
    localparam logic [2:0] K_BEQ   = 3'd3;
    localparam logic [2:0] K_ADDI  = 3'd4;
    localparam logic [2:0] K_J     = 3'd5;
    localparam logic [2:0] K_END   = 3'd6;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;

    logic accept, full, is_data, wr_fire, do_restart;
    logic [31:0] enc_word;

    assign accept     = in_valid && in_ready;
    assign full       = (count_q == DEPTH);
    assign is_data    = (in_kind <= K_J);
    assign wr_fire    = accept && is_data && !full;
    assign do_restart = restart && (state_q != S_LOAD);

    // Only the opcodes the core's main decoder understands are ever produced.
    always_comb begin
        enc_word = 32'h0;
        unique case (in_kind)
            K_RTYPE: enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            K_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            K_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            K_BEQ:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
            K_ADDI:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
            K_J:     enc_word = {6'b000010, in_target};
            default: enc_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_LOAD;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (in_kind == K_END)      state_d = S_DONE;
                    else if (!is_data || full) state_d = S_ERROR;
                end
            end
            S_DONE, S_ERROR: if (restart) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERROR);
        cpu_reset = (state_q != S_DONE);
    end

    // Address and data hold their last value when no write is pending.
    always_comb begin
        we_d    = wr_fire;
        addr_d  = wr_fire ? count_q[ADDR_W-1:0] : addr_q;
        wd_d    = wr_fire ? enc_word : wd_q;
        count_d = count_q;
        if (do_restart)   count_d = '0;
        else if (wr_fire) count_d = count_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= 32'h0;
            count_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            count_q <= count_d;
        end
    end

    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: a 64-word and a 4-word instance share stimulus and are
// each compared every cycle against a behavioural model of the load protocol.
module tb_mips_prog_loader;

    logic clk = 1'b0;
    logic reset_n, restart, in_valid;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic rdy_a, we_a, cr_a, dn_a, er_a;
    logic [5:0] addr_a; logic [31:0] wd_a; logic [6:0] cnt_a;
    logic rdy_b, we_b, cr_b, dn_b, er_b;
    logic [1:0] addr_b; logic [31:0] wd_b; logic [2:0] cnt_b;

    always #5 clk = ~clk;

    mips_prog_loader #(.ADDR_W(6)) dut_a (
        .clk(clk), .reset_n(reset_n), .restart(restart), .in_valid(in_valid), .in_ready(rdy_a),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wd(wd_a), .cpu_reset(cr_a),
        .done(dn_a), .err(er_a), .count(cnt_a));

    mips_prog_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .restart(restart), .in_valid(in_valid), .in_ready(rdy_b),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wd(wd_b), .cpu_reset(cr_b),
        .done(dn_b), .err(er_b), .count(cnt_b));

    int nvec = 0, nerr = 0;

    // Model: phase 0 loading, 1 finished, 2 aborted
    int          ms[2], mcnt[2], maddr[2];
    bit          mwe[2];
    logic [31:0] mwd[2];
    int          dep[2] = '{64, 4};
    int          opc[6] = '{0, 35, 43, 4, 8, 2};

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_ref(int k);
        logic [31:0] op;
        op = 32'(opc[k]) * 32'h0400_0000;
        if (k == 0)
            return op + 32'(in_rs) * 32'h20_0000 + 32'(in_rt) * 32'h1_0000 +
                   32'(in_rd) * 32'h800 + 32'(in_shamt) * 32'h40 + 32'(in_funct);
        else if (k == 5)
            return op + 32'(in_target);
        else
            return op + 32'(in_rs) * 32'h20_0000 + 32'(in_rt) * 32'h1_0000 + 32'(in_imm);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mcnt[i] = 0; maddr[i] = 0; mwe[i] = 0; mwd[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            mwe[i] = 0;
            if (ms[i] == 0) begin
                if (in_valid) begin
                    if (in_kind == 3'd6) ms[i] = 1;
                    else if (in_kind == 3'd7 || mcnt[i] == dep[i]) ms[i] = 2;
                    else begin
                        mwe[i] = 1; maddr[i] = mcnt[i]; mwd[i] = enc_ref(int'(in_kind));
                        mcnt[i]++;
                    end
                end
            end else if (restart) begin
                ms[i] = 0; mcnt[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("a_we",    32'(we_a),  32'(mwe[0]));
        chk("a_count", 32'(cnt_a), 32'(mcnt[0]));
        chk("a_ready", 32'(rdy_a), 32'(ms[0] == 0));
        chk("a_done",  32'(dn_a),  32'(ms[0] == 1));
        chk("a_err",   32'(er_a),  32'(ms[0] == 2));
        chk("a_cpurst",32'(cr_a),  32'(ms[0] != 1));
        if (mwe[0]) begin
            chk("a_addr", 32'(addr_a), 32'(maddr[0]));
            chk("a_wd",   wd_a,        mwd[0]);
        end
        chk("b_we",    32'(we_b),  32'(mwe[1]));
        chk("b_count", 32'(cnt_b), 32'(mcnt[1]));
        chk("b_ready", 32'(rdy_b), 32'(ms[1] == 0));
        chk("b_done",  32'(dn_b),  32'(ms[1] == 1));
        chk("b_err",   32'(er_b),  32'(ms[1] == 2));
        chk("b_cpurst",32'(cr_b),  32'(ms[1] != 1));
        if (mwe[1]) begin
            chk("b_addr", 32'(addr_b), 32'(maddr[1]));
            chk("b_wd",   wd_b,        mwd[1]);
        end
    endtask

    // Inputs change at negedge; the model samples them at the posedge like the DUT.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic beat(input logic v, input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tgt);
        in_valid = v; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
    endtask

    task automatic data(input logic [2:0] k);
        beat(1'b1, k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},   32'(we_a),  0); chk({tag, "_addr"}, 32'(addr_a), 0);
        chk({tag, "_wd"},   wd_a,       0); chk({tag, "_cnt"},  32'(cnt_a),  0);
        chk({tag, "_crst"}, 32'(cr_a),  1); chk({tag, "_done"}, 32'(dn_a),   0);
        chk({tag, "_err"},  32'(er_a),  0); chk({tag, "_bwe"},  32'(we_b),   0);
        chk({tag, "_bcnt"}, 32'(cnt_b), 0); chk({tag, "_berr"}, 32'(er_b),   0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; restart = 1'b0;
        beat(1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        #1 model_reset();
        check_reset_vals("rst");
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rst_ready", 32'(rdy_a), 1);
        @(negedge clk);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{3'd4, 5'd0, 5'd8, 5'd0,  5'd0, 6'h00, 16'h0005, 26'h0,  32'h20080005};
        tbl[1] = '{3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0000, 26'h0,  32'h01095020};
        tbl[2] = '{3'd1, 5'd0, 5'd8, 5'd0,  5'd0, 6'h00, 16'h0004, 26'h0,  32'h8C080004};
        tbl[3] = '{3'd2, 5'd0, 5'd8, 5'd0,  5'd0, 6'h00, 16'h0004, 26'h0,  32'hAC080004};
        tbl[4] = '{3'd3, 5'd8, 5'd9, 5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h0,  32'h1109FFFF};
        tbl[5] = '{3'd5, 5'd0, 5'd0, 5'd0,  5'd0, 6'h00, 16'h0000, 26'h10, 32'h08000010};

        reset_n = 1'b1; restart = 1'b0;
        beat(1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Known encodings, back-to-back
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh,
                 tbl[i].fn, tbl[i].imm, tbl[i].tgt);
            @(posedge clk); model_step();
            #1 check_all();
            chk("tbl_we",   32'(we_a),   1);
            chk("tbl_addr", 32'(addr_a), 32'(i));
            chk("tbl_wd",   wd_a,        tbl[i].exp);
            @(negedge clk);
        end
        beat(1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        beat(1'b1, 3'd6, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("end_done", 32'(dn_a), 1); chk("end_crst", 32'(cr_a), 0);
        chk("end_rdy",  32'(rdy_a), 0); chk("end_cnt", 32'(cnt_a), 6);
        data(3'd1); tick(); tick();
        chk("end_nowr", 32'(we_a), 0);

        // Four-word instance fills then overflows; restart recovers it
        do_reset();
        for (int i = 0; i < 5; i++) begin data(3'($urandom_range(0, 5))); tick(); end
        chk("ovf_err", 32'(er_b), 1); chk("ovf_cnt", 32'(cnt_b), 4); chk("ovf_we", 32'(we_b), 0);
        beat(1'b1, 3'd2, 0, 0, 0, 0, 0, 0, 0); restart = 1'b1; tick(); restart = 1'b0;
        chk("rs_err", 32'(er_b), 0); chk("rs_cnt", 32'(cnt_b), 0); chk("rs_crst", 32'(cr_b), 1);
        chk("rs_nowe", 32'(we_b), 0);
        data(3'd4); tick();
        chk("rs_addr0", 32'(addr_b), 0); chk("rs_we", 32'(we_b), 1);

        // Illegal kind: ignored when not valid, aborts when valid
        do_reset();
        beat(1'b0, 3'd7, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("k7_idle", 32'(er_a), 0);
        beat(1'b1, 3'd7, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("k7_err", 32'(er_a), 1); chk("k7_we", 32'(we_a), 0);

        // Asynchronous reset during a pending write strobe
        do_reset();
        data(3'd0); tick(); data(3'd4); tick();
        chk("mid_we", 32'(we_a), 1);
        reset_n = 1'b0; beat(1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        #1 model_reset(); check_reset_vals("mid");
        @(negedge clk); reset_n = 1'b1; @(negedge clk);
        data(3'd3); tick();
        chk("mid_addr0", 32'(addr_a), 0);

        // Random traffic with occasional END, illegal beats and restarts
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       data(3'd6);
            else if (r < 5)  data(3'd7);
            else             data(3'($urandom_range(0, 5)));
            in_valid = ($urandom_range(0, 3) != 0);
            restart  = ($urandom_range(0, 19) == 0);
            tick();
        end
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
